// File: rtl/conn_setup_sequencer.sv
// Connection-setup sequencer: arbitrates two requesters, emits the ConnSetupFrame
// command sequence to the RPC unit, then waits for completion, RPC error or timeout.
module conn_setup_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CONN_ID_W      = 16,
  parameter int unsigned FLOW_ID_W      = 16,
  localparam int unsigned CMD_W   = 3,
  localparam int unsigned DATA_W  = (CONN_ID_W > 32) ?
                                    ((CONN_ID_W > FLOW_ID_W) ? CONN_ID_W : FLOW_ID_W) :
                                    ((FLOW_ID_W > 32) ? FLOW_ID_W : 32),
  localparam int unsigned FRAME_W = CMD_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_open,
  input  logic [1:0][CONN_ID_W-1:0] req_conn_id,
  input  logic [1:0][31:0]          req_dest_ip,
  input  logic [1:0][15:0]          req_dest_port,
  input  logic [1:0][FLOW_ID_W-1:0] req_client_flow_id,
  output logic                      conn_setup_en_out,
  output logic [FRAME_W-1:0]        conn_setup_frame_out,
  input  logic                      status_valid_in,
  input  logic [CONN_ID_W-1:0]      status_conn_id_in,
  input  logic                      status_error_in,
  input  logic                      rpc_error_in,
  output logic                      resp_valid,
  output logic                      resp_requester,
  output logic [1:0]                resp_code,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_e;

  // Frame layout is {cmd, data}; cmd encoding is shared with the RPC unit.
  typedef enum logic [CMD_W-1:0] {
    CMD_CONN_ID = 3'd0,
    CMD_OPEN    = 3'd1,
    CMD_DEST_IP = 3'd2,
    CMD_PORT    = 3'd3,
    CMD_FLOW_ID = 3'd4,
    CMD_ENABLE  = 3'd5
  } cmd_e;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 gnt_q, gnt_d;
  logic                 open_q, open_d;
  logic [CONN_ID_W-1:0] id_q, id_d;
  logic [31:0]          ip_q, ip_d;
  logic [15:0]          port_q, port_d;
  logic [FLOW_ID_W-1:0] flow_q, flow_d;
  logic [2:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic                 rpc_q, rpc_d;

  logic                 gnt;
  logic [1:0]           code_d;
  cmd_e                 cmd;
  logic [DATA_W-1:0]    data;
  logic                 en_d;
  logic [FRAME_W-1:0]   frame_d;
  logic                 resp_valid_d;
  logic                 resp_requester_d;
  logic [1:0]           resp_code_d;
  logic                 busy_d;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    open_d  = open_q;
    id_d    = id_q;
    ip_d    = ip_q;
    port_d  = port_q;
    flow_d  = flow_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rpc_d   = rpc_q;
    code_d  = 2'd0;
    req_ready = 2'b00;
    gnt     = req_valid[rr_q] ? rr_q : ~rr_q;
    cmd     = CMD_ENABLE;
    data    = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready[gnt] = req_valid[gnt];
        if (|req_valid) begin
          gnt_d   = gnt;
          rr_d    = ~gnt;
          open_d  = req_open[gnt];
          id_d    = req_conn_id[gnt];
          ip_d    = req_dest_ip[gnt];
          port_d  = req_dest_port[gnt];
          flow_d  = req_client_flow_id[gnt];
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (idx_q == (open_q ? 3'd5 : 3'd2)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          to_d    = 1'b0;
          rpc_d   = rpc_error_in;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_WAIT: begin
        // Timeout is flagged one cycle after the counter reaches its limit.
        cnt_d = cnt_q + CNT_W'(1);
        to_d  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (status_valid_in && (status_conn_id_in == id_q)) begin
          state_d = ST_RESP;
          code_d  = status_error_in ? 2'd1 : 2'd0;
        end else if (rpc_error_in && !rpc_q) begin
          state_d = ST_RESP;
          code_d  = 2'd3;
        end else if (to_q) begin
          state_d = ST_RESP;
          code_d  = 2'd2;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Close sequence skips the open-only fields.
    if (open_d) begin
      cmd = cmd_e'(idx_d);
    end else begin
      unique case (idx_d)
        3'd0:    cmd = CMD_CONN_ID;
        3'd1:    cmd = CMD_OPEN;
        default: cmd = CMD_ENABLE;
      endcase
    end

    unique case (cmd)
      CMD_CONN_ID: data = DATA_W'(id_d);
      CMD_OPEN:    data = DATA_W'(open_d);
      CMD_DEST_IP: data = DATA_W'(ip_d);
      CMD_PORT:    data = DATA_W'(port_d);
      CMD_FLOW_ID: data = DATA_W'(flow_d);
      default:     data = '0;
    endcase

    en_d             = (state_d == ST_SEND);
    frame_d          = en_d ? {cmd, data} : '0;
    resp_valid_d     = (state_d == ST_RESP);
    resp_requester_d = resp_valid_d ? gnt_d : 1'b0;
    resp_code_d      = resp_valid_d ? code_d : 2'd0;
    busy_d           = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= ST_IDLE;
      rr_q                 <= 1'b0;
      gnt_q                <= 1'b0;
      open_q               <= 1'b0;
      id_q                 <= '0;
      ip_q                 <= '0;
      port_q               <= '0;
      flow_q               <= '0;
      idx_q                <= '0;
      cnt_q                <= '0;
      to_q                 <= 1'b0;
      rpc_q                <= 1'b0;
      conn_setup_en_out    <= 1'b0;
      conn_setup_frame_out <= '0;
      resp_valid           <= 1'b0;
      resp_requester       <= 1'b0;
      resp_code            <= 2'd0;
      busy                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      rr_q                 <= rr_d;
      gnt_q                <= gnt_d;
      open_q               <= open_d;
      id_q                 <= id_d;
      ip_q                 <= ip_d;
      port_q               <= port_d;
      flow_q               <= flow_d;
      idx_q                <= idx_d;
      cnt_q                <= cnt_d;
      to_q                 <= to_d;
      rpc_q                <= rpc_d;
      conn_setup_en_out    <= en_d;
      conn_setup_frame_out <= frame_d;
      resp_valid           <= resp_valid_d;
      resp_requester       <= resp_requester_d;
      resp_code            <= resp_code_d;
      busy                 <= busy_d;
    end
  end

endmodule

// File: tb/tb_conn_setup_sequencer.sv
// Scoreboard bench for conn_setup_sequencer: expected frames and responses are
// queued with their due cycle at acceptance and compared as the DUT emits them.
module tb_conn_setup_sequencer;

  localparam int unsigned TO = 8;
  localparam int unsigned FW = 35;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_open;
  logic [1:0][15:0]  req_conn_id;
  logic [1:0][31:0]  req_dest_ip;
  logic [1:0][15:0]  req_dest_port;
  logic [1:0][15:0]  req_client_flow_id;
  logic              conn_setup_en_out;
  logic [FW-1:0]     conn_setup_frame_out;
  logic              status_valid_in;
  logic [15:0]       status_conn_id_in;
  logic              status_error_in;
  logic              rpc_error_in;
  logic              resp_valid;
  logic              resp_requester;
  logic [1:0]        resp_code;
  logic              busy;

  conn_setup_sequencer #(.TIMEOUT_CYCLES(TO), .CONN_ID_W(16), .FLOW_ID_W(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_open             (req_open),
    .req_conn_id          (req_conn_id),
    .req_dest_ip          (req_dest_ip),
    .req_dest_port        (req_dest_port),
    .req_client_flow_id   (req_client_flow_id),
    .conn_setup_en_out    (conn_setup_en_out),
    .conn_setup_frame_out (conn_setup_frame_out),
    .status_valid_in      (status_valid_in),
    .status_conn_id_in    (status_conn_id_in),
    .status_error_in      (status_error_in),
    .rpc_error_in         (rpc_error_in),
    .resp_valid           (resp_valid),
    .resp_requester       (resp_requester),
    .resp_code            (resp_code),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] frame; int unsigned at; } exp_frame_t;
  typedef struct { logic req; logic [1:0] code; int unsigned at; } exp_resp_t;

  exp_frame_t  fq[$];
  exp_resp_t   rq[$];
  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the head of its queue, on the due cycle.
  always @(negedge clk) begin
    exp_frame_t ef;
    exp_resp_t  er;
    if (conn_setup_en_out === 1'b1) begin
      n_vec++;
      if (fq.size() == 0) begin
        n_err++;
        $display("FAIL frame_unexpected: got %h at cycle %0d, required no frame", conn_setup_frame_out, cyc);
      end else begin
        ef = fq.pop_front();
        if (conn_setup_frame_out !== ef.frame || cyc != ef.at) begin
          n_err++;
          $display("FAIL frame: got %h at cycle %0d, required %h at cycle %0d",
                   conn_setup_frame_out, cyc, ef.frame, ef.at);
        end
      end
    end
    if (resp_valid === 1'b1) begin
      n_vec++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: got req %b code %0d at cycle %0d, required no response",
                 resp_requester, resp_code, cyc);
      end else begin
        er = rq.pop_front();
        if (resp_requester !== er.req || resp_code !== er.code || cyc != er.at) begin
          n_err++;
          $display("FAIL resp: got req %b code %0d at cycle %0d, required req %b code %0d at cycle %0d",
                   resp_requester, resp_code, cyc, er.req, er.code, er.at);
        end
      end
    end
    if (req_ready !== 2'b00) begin
      n_vec++;
      if ($countones(req_ready) > 1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL req_ready_excl: got ready %b busy %b, required one-hot ready with busy 0", req_ready, busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) step();
  endtask

  function automatic logic [FW-1:0] mk(input int unsigned cmd, input logic [31:0] data);
    return {3'(cmd), data};
  endfunction

  task automatic push_open(input int unsigned t, input logic [15:0] id, input logic [31:0] ip,
                           input logic [15:0] port, input logic [15:0] flow, input int nfr);
    logic [FW-1:0] f [6];
    f[0] = mk(0, 32'(id));
    f[1] = mk(1, 32'd1);
    f[2] = mk(2, ip);
    f[3] = mk(3, 32'(port));
    f[4] = mk(4, 32'(flow));
    f[5] = mk(5, 32'd0);
    for (int i = 0; i < nfr; i++) fq.push_back('{frame: f[i], at: t + 1 + i});
  endtask

  task automatic push_close(input int unsigned t, input logic [15:0] id);
    fq.push_back('{frame: mk(0, 32'(id)), at: t + 1});
    fq.push_back('{frame: mk(1, 32'd0),   at: t + 2});
    fq.push_back('{frame: mk(5, 32'd0),   at: t + 3});
  endtask

  task automatic push_resp(input logic r, input logic [1:0] code, input int unsigned at);
    rq.push_back('{req: r, code: code, at: at});
  endtask

  // Present a request on port r, return the accept cycle, drop valid afterwards.
  task automatic issue(input int r, input logic op, input logic [15:0] id, input logic [31:0] ip,
                       input logic [15:0] port, input logic [15:0] flow, output int unsigned t);
    bit got = 0;
    req_open[r]           = op;
    req_conn_id[r]        = id;
    req_dest_ip[r]        = ip;
    req_dest_port[r]      = port;
    req_client_flow_id[r] = flow;
    req_valid[r]          = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) begin
        got = 1;
        break;
      end
    end
    t = cyc;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_timeout: requester %0d got no req_ready, required one within 40 cycles", r);
    end
    step();
    req_valid[r] = 1'b0;
  endtask

  task automatic pulse_status(input logic [15:0] id, input logic err);
    status_valid_in   = 1'b1;
    status_conn_id_in = id;
    status_error_in   = err;
    step();
    status_valid_in   = 1'b0;
    status_error_in   = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (fq.size() != 0 || rq.size() != 0); i++) step();
    n_vec++;
    if (fq.size() != 0 || rq.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d frames and %0d responses outstanding, required 0", name, fq.size(), rq.size());
    end
    step();
    step();
  endtask

  task automatic check_idle_outputs(input string name);
    logic [FW+7:0] got;
    got = {req_ready, conn_setup_en_out, conn_setup_frame_out, resp_valid, resp_requester, resp_code, busy};
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL %s: outputs ready %b en %b frame %h rv %b rr %b code %0d busy %b, required all 0",
               name, req_ready, conn_setup_en_out, conn_setup_frame_out, resp_valid, resp_requester, resp_code, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_idle_outputs("reset_async");
    step();
    step();
    check_idle_outputs("reset_hold");
    reset = 1'b1;
    step();
  endtask

  task automatic test_open_req0();
    int unsigned t, w;
    issue(0, 1'b1, 16'h0005, 32'h0A00_0001, 16'h1F90, 16'd3, t);
    push_open(t, 16'h0005, 32'h0A00_0001, 16'h1F90, 16'd3, 6);
    w = t + 7;
    goto(t + 2);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL open_busy: busy %b, required 1", busy);
    end
    goto(w + 4);
    push_resp(1'b0, 2'd0, w + 5);
    pulse_status(16'h0005, 1'b0);
    goto(w + 6);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL open_idle: busy %b two cycles after status, required 0", busy);
    end
    drain("open_req0");
  endtask

  task automatic test_close_req1();
    int unsigned t, w;
    issue(1, 1'b0, 16'h0007, 32'h0, 16'h0, 16'h0, t);
    push_close(t, 16'h0007);
    w = t + 4;
    goto(w + 1);
    push_resp(1'b1, 2'd1, w + 2);
    pulse_status(16'h0007, 1'b1);
    drain("close_req1");
  endtask

  task automatic test_round_robin();
    int unsigned t, w;
    logic g;
    logic [15:0] id;
    req_open           = 2'b00;
    req_conn_id[0]     = 16'h0011;
    req_conn_id[1]     = 16'h0022;
    req_valid          = 2'b11;
    for (int k = 0; k < 3; k++) begin
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (req_ready !== 2'b00) begin
          got = 1;
          break;
        end
      end
      t = cyc;
      g = req_ready[1];
      n_vec++;
      if (!got || g !== 1'(k % 2)) begin
        n_err++;
        $display("FAIL rr_grant%0d: got ready %b, required grant to requester %0d", k, req_ready, k % 2);
      end
      id = g ? 16'h0022 : 16'h0011;
      push_close(t, id);
      step();
      if (k == 2) req_valid = 2'b00;
      w = t + 4;
      goto(w);
      push_resp(g, 2'd0, w + 1);
      pulse_status(id, 1'b0);
    end
    drain("round_robin");
  endtask

  task automatic test_timeout();
    int unsigned t, w;
    issue(0, 1'b0, 16'h0030, 32'h0, 16'h0, 16'h0, t);
    push_close(t, 16'h0030);
    w = t + 4;
    goto(t + 2);
    pulse_status(16'h0030, 1'b0);
    goto(w + 3);
    pulse_status(16'h0009, 1'b0);
    goto(w + 8);
    n_vec++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: busy %b resp_valid %b at WAIT+8, required busy 1 resp_valid 0", busy, resp_valid);
    end
    push_resp(1'b0, 2'd2, w + 9);
    drain("timeout");
  endtask

  task automatic test_coincident();
    int unsigned t, w;
    issue(1, 1'b0, 16'h0041, 32'h0, 16'h0, 16'h0, t);
    push_close(t, 16'h0041);
    w = t + 4;
    goto(w + 2);
    push_resp(1'b1, 2'd0, w + 3);
    rpc_error_in = 1'b1;
    pulse_status(16'h0041, 1'b0);
    rpc_error_in = 1'b0;
    drain("coincident");
    issue(0, 1'b0, 16'h0042, 32'h0, 16'h0, 16'h0, t);
    push_close(t, 16'h0042);
    w = t + 4;
    goto(w + 3);
    push_resp(1'b0, 2'd3, w + 4);
    rpc_error_in = 1'b1;
    step();
    rpc_error_in = 1'b0;
    drain("rpc_error");
  endtask

  task automatic test_reset_mid_send();
    int unsigned t, w;
    issue(1, 1'b1, 16'h0055, 32'hC0A8_0101, 16'h0050, 16'd9, t);
    push_open(t, 16'h0055, 32'hC0A8_0101, 16'h0050, 16'd9, 2);
    goto(t + 3);
    #1 reset = 1'b0;
    #1 check_idle_outputs("reset_mid_send");
    step();
    step();
    reset = 1'b1;
    repeat (15) step();
    issue(0, 1'b1, 16'h0056, 32'h0A0B_0C0D, 16'h1234, 16'd7, t);
    push_open(t, 16'h0056, 32'h0A0B_0C0D, 16'h1234, 16'd7, 6);
    w = t + 7;
    goto(w + 1);
    push_resp(1'b0, 2'd0, w + 2);
    pulse_status(16'h0056, 1'b0);
    drain("reopen");
  endtask

  initial begin
    req_valid          = '0;
    req_open           = '0;
    req_conn_id        = '0;
    req_dest_ip        = '0;
    req_dest_port      = '0;
    req_client_flow_id = '0;
    status_valid_in    = 1'b0;
    status_conn_id_in  = '0;
    status_error_in    = 1'b0;
    rpc_error_in       = 1'b0;
    test_reset();
    test_open_req0();
    test_close_req1();
    test_round_robin();
    test_timeout();
    test_coincident();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conn_setup_sequencer.md
# conn_setup_sequencer

Drives the connection-setup port of the RPC unit: accepts whole open/close requests from two requesters (0 = host CSR path, 1 = NIC-internal teardown), shares the single setup port between them round-robin, and emits the per-field ConnSetupFrame command sequence. It then waits for the connection manager's completion status, or a timeout, and returns a one-cycle response to the granted requester. It sits between the control/CSR logic and the `conn_setup_en_in`/`conn_setup_frame_in` inputs of the RPC unit.

## Interface
- TIMEOUT_CYCLES, 256: cycles to wait in WAIT before declaring timeout (≥2)
- CONN_ID_W, 16: connection id width
- FLOW_ID_W, 16: client flow id width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_open  in  2  1 = open, 0 = close (per requester)
- req_conn_id  in  2×CONN_ID_W  connection id (per requester)
- req_dest_ip  in  2×32  destination IPv4 (open only)
- req_dest_port  in  2×16  destination port (open only)
- req_client_flow_id  in  2×FLOW_ID_W  client flow id (open only)
- conn_setup_en_out  out  1  frame strobe to the RPC unit
- conn_setup_frame_out  out  ConnSetupFrame  cmd + data (data zero-extended)
- status_valid_in  in  1  connection manager completion pulse
- status_conn_id_in  in  CONN_ID_W  id the completion refers to
- status_error_in  in  1  completion reports failure
- rpc_error_in  in  1  RPC unit error flag (level)
- resp_valid  out  1  one-cycle response pulse
- resp_requester  out  1  requester the response belongs to
- resp_code  out  2  0 OK, 1 STATUS_ERR, 2 TIMEOUT, 3 RPC_ERR
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SEND, WAIT, RESP.
- IDLE: `req_ready[g]` = `req_valid[g]` for granted g (combinational). Grant goes to the requester pointed to by rr_ptr if valid, else the other. On accept, latch all fields and g, flip rr_ptr to ~g, → SEND with frame index 0.
- SEND: one frame per cycle, `conn_setup_en_out` = 1.
  - Open order: setUpConnId(conn_id), setUpOpen(1), setUpDestIPv4(ip), setUpDestPort(port), setUpClientFlowId(flow), setUpEnable(0) — 6 frames.
  - Close order: setUpConnId(conn_id), setUpOpen(0), setUpEnable(0) — 3 frames. setUpOpen is always sent so the RPC unit never reuses a stale open flag.
  - After the setUpEnable frame → WAIT; clear timeout counter.
- WAIT: the counter increments every cycle.
  - `status_valid_in` with `status_conn_id_in` == latched id → RESP with code = status_error_in ? 1 : 0.
  - Else `rpc_error_in` rising edge (vs. the value latched on entering WAIT) → RESP code 3.
  - Else counter == TIMEOUT_CYCLES-1 → RESP code 2.
  - Priority when coincident: status > rpc_error > timeout.
  - Status with a non-matching id, or any status outside WAIT: ignored.
- RESP: `resp_valid` = 1 for one cycle with latched requester/code → IDLE.
- Requests are never queued; a requester holds `req_valid` (and fields) until `req_ready`.

## Timing
- Reset (reset=0, async): state IDLE, rr_ptr=0, counter=0; `req_ready`=0, `conn_setup_en_out`=0, `conn_setup_frame_out`=0, `resp_valid`=0, `resp_requester`=0, `resp_code`=0, `busy`=0. All registered outputs drive zero when not active.
- Accept at cycle T → frames on T+1..T+6 (open) or T+1..T+3 (close); WAIT from T+7 / T+4.
- Status sampled at cycle S in WAIT → `resp_valid` at S+1; IDLE at S+2; next accept no earlier than S+2.
- Timeout: with no status, `resp_valid` arrives TIMEOUT_CYCLES+1 cycles after WAIT entry.
- `conn_setup_frame_out` is registered; cmd/data are valid only while `conn_setup_en_out`=1.
- Reset mid-SEND/WAIT: sequence abandoned, no response. The next request re-sends every field.

## Test plan
- Open from req 0 (id 0x0005, ip 0x0A000001, port 0x1F90, flow 3); status id 5, err 0, 4 cycles into WAIT -> 6 frames in order on T+1..T+6; resp_valid at WAIT+5 with req 0, code 0.
- Close from req 1 (id 7); status id 7, err 1 -> frames ConnId(7), Open(0), Enable; resp code 1, requester 1.
- Both req_valid high continuously, rr_ptr=0 -> grants alternate 0,1,0; req_ready never high in both bits or outside IDLE.
- TIMEOUT_CYCLES=8, no status; status id 9 (mismatched) mid-WAIT -> ignored; resp code 2 exactly 9 cycles after WAIT entry.
- Status and rpc_error rise in the same WAIT cycle -> code from status; rpc_error alone -> code 3.
- Assert reset at the 3rd frame of an open -> all outputs 0 asynchronously, no resp. A new open after release emits all 6 frames.
